// File: rtl/move_sequencer.sv
// 2048 board controller: owns the 4x4 exponent grid, streams each move's four
// lines through an external merger, spawns a random tile and tracks win/lose.
module move_sequencer #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          WIN_EXP = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  direction,
  input  logic        load_en,
  input  logic [63:0] load_grid,
  output logic [15:0] line_to_merge,
  input  logic [15:0] line_from_merge,
  output logic [63:0] grid_flat,
  output logic [1:0]  state,
  output logic        busy,
  output logic        move_done
);

  typedef enum logic [2:0] {
    S_INIT0, S_INIT1, S_IDLE, S_MERGE, S_SPAWN, S_CHECK
  } fsm_e;

  localparam logic [15:0] SEED_FIX = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [4:0]  WIN_LIM  = 5'(WIN_EXP);

  fsm_e        fsm_q;
  logic [63:0] grid_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  prev_dir_q, dir_q;
  logic [1:0]  k_q;
  logic        changed_q;
  logic [1:0]  state_q;
  logic        done_q;

  logic [63:0] merge_grid, spawn_grid;
  logic [3:0]  spawn_idx;
  logic        spawn_found;
  logic        any_win, any_empty, any_pair;
  logic        dir_onehot;

  // Element j of line k; every direction compacts toward element 3.
  function automatic logic [3:0] cell_idx(input logic [3:0] dir, input logic [1:0] k,
                                          input logic [1:0] j);
    case (dir)
      4'b1000: cell_idx = {k, ~j};
      4'b0100: cell_idx = {~j, k};
      4'b0010: cell_idx = {j, k};
      default: cell_idx = {k, j};
    endcase
  endfunction

  assign lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
  assign dir_onehot = (direction == 4'b0001) || (direction == 4'b0010) ||
                      (direction == 4'b0100) || (direction == 4'b1000);

  always_comb begin
    line_to_merge = '0;
    merge_grid    = grid_q;
    for (int j = 0; j < 4; j++) begin
      if (fsm_q == S_MERGE)
        line_to_merge[4*j +: 4] = grid_q[{cell_idx(dir_q, k_q, 2'(j)), 2'b00} +: 4];
      merge_grid[{cell_idx(dir_q, k_q, 2'(j)), 2'b00} +: 4] = line_from_merge[4*j +: 4];
    end
  end

  // Descending scan so the last hit is the first empty cell after lfsr[3:0].
  always_comb begin
    spawn_found = 1'b0;
    spawn_idx   = '0;
    for (int i = 15; i >= 0; i--) begin
      if (grid_q[{lfsr_q[3:0] + 4'(i), 2'b00} +: 4] == 4'd0) begin
        spawn_found = 1'b1;
        spawn_idx   = lfsr_q[3:0] + 4'(i);
      end
    end
    spawn_grid = grid_q;
    spawn_grid[{spawn_idx, 2'b00} +: 4] = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
  end

  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ({1'b0, grid_q[4*i +: 4]} >= WIN_LIM) any_win = 1'b1;
      if (grid_q[4*i +: 4] == 4'd0) any_empty = 1'b1;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (grid_q[16*r + 4*c +: 4] == grid_q[16*r + 4*c + 4 +: 4]) any_pair = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (grid_q[16*r + 4*c +: 4] == grid_q[16*r + 4*c + 16 +: 4]) any_pair = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q      <= S_INIT0;
      grid_q     <= '0;
      lfsr_q     <= SEED_FIX;
      prev_dir_q <= '0;
      dir_q      <= '0;
      k_q        <= '0;
      changed_q  <= 1'b0;
      state_q    <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      prev_dir_q <= direction;
      done_q     <= (fsm_q == S_CHECK);
      case (fsm_q)
        S_INIT0: begin
          if (spawn_found) grid_q <= spawn_grid;
          fsm_q <= S_INIT1;
        end
        S_INIT1: begin
          if (spawn_found) grid_q <= spawn_grid;
          fsm_q <= S_IDLE;
        end
        S_IDLE: begin
          if (load_en) begin
            grid_q <= load_grid;
            fsm_q  <= S_CHECK;
          end else if (dir_onehot && prev_dir_q == 4'd0 && state_q == 2'd0) begin
            dir_q     <= direction;
            k_q       <= '0;
            changed_q <= 1'b0;
            fsm_q     <= S_MERGE;
          end
        end
        S_MERGE: begin
          grid_q    <= merge_grid;
          changed_q <= changed_q | (line_from_merge != line_to_merge);
          k_q       <= k_q + 2'd1;
          if (k_q == 2'd3) fsm_q <= S_SPAWN;
        end
        S_SPAWN: begin
          if (changed_q && spawn_found) grid_q <= spawn_grid;
          fsm_q <= S_CHECK;
        end
        S_CHECK: begin
          if (state_q == 2'd0) begin
            if (any_win) state_q <= 2'd1;
            else if (!any_empty && !any_pair) state_q <= 2'd2;
          end
          fsm_q <= S_IDLE;
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = rst && (fsm_q != S_IDLE);
  assign grid_flat = grid_q;
  assign state     = state_q;
  assign move_done = done_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Randomised self-checking bench for move_sequencer: a line-merge golden model
// acts as the external merger and a board-level model predicts every move.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  direction;
  logic        loadEn;
  logic [63:0] loadGrid;
  logic [15:0] lineToMerge;
  logic [15:0] lineFromMerge;
  logic [63:0] gridFlat;
  logic [1:0]  state;
  logic        busy;
  logic        moveDone;

  int checks = 0;
  int errors = 0;
  int model[16];
  int modelState;
  int edgeCount = 0;

  move_sequencer dut (
    .clk(clk), .rst(rst), .direction(direction), .load_en(loadEn),
    .load_grid(loadGrid), .line_to_merge(lineToMerge), .line_from_merge(lineFromMerge),
    .grid_flat(gridFlat), .state(state), .busy(busy), .move_done(moveDone)
  );

  always #5 clk = ~clk;

  // Counts clock edges since reset release, which is what the LFSR has seen.
  always @(posedge clk or negedge rst)
    if (!rst) edgeCount <= 0;
    else      edgeCount <= edgeCount + 1;

  // 2048 line rule: gather tiles nearest element 3 first, pair equal neighbours once.
  function automatic logic [15:0] mergeLine(logic [15:0] lineIn);
    int vals[4];
    int n = 0;
    int pos = 3;
    int i = 0;
    logic [15:0] res = '0;
    for (int j = 3; j >= 0; j--)
      if (lineIn[4*j +: 4] != 4'd0) begin
        vals[n] = int'(lineIn[4*j +: 4]);
        n++;
      end
    while (i < n) begin
      if (i + 1 < n && vals[i] == vals[i+1]) begin
        res[4*pos +: 4] = 4'(vals[i] + 1);
        i += 2;
      end else begin
        res[4*pos +: 4] = 4'(vals[i]);
        i++;
      end
      pos--;
    end
    return res;
  endfunction

  assign lineFromMerge = mergeLine(lineToMerge);

  function automatic logic [15:0] lfsrAt(int n);
    logic [15:0] l = 16'hACE1;
    for (int i = 0; i < n; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    return l;
  endfunction

  function automatic int cellOf(logic [3:0] dir, int k, int j);
    case (dir)
      4'b0001: return 4*k + j;
      4'b1000: return 4*k + 3 - j;
      4'b0010: return 4*j + k;
      default: return 4*(3 - j) + k;
    endcase
  endfunction

  function automatic logic [63:0] packModel();
    logic [63:0] p = '0;
    for (int i = 0; i < 16; i++) p[4*i +: 4] = 4'(model[i]);
    return p;
  endfunction

  function automatic void modelSpawn(logic [15:0] l);
    int start = int'(l[3:0]);
    for (int i = 0; i < 16; i++)
      if (model[(start + i) % 16] == 0) begin
        model[(start + i) % 16] = (l[7:4] == 4'd0) ? 2 : 1;
        return;
      end
  endfunction

  function automatic void modelCheck();
    bit win = 0;
    bit open = 0;
    if (modelState != 0) return;
    for (int i = 0; i < 16; i++) begin
      if (model[i] >= 11) win = 1;
      if (model[i] == 0) open = 1;
      if (i % 4 != 3 && model[i] == model[i+1]) open = 1;
      if (i < 12 && model[i] == model[i+4]) open = 1;
    end
    if (win) modelState = 1;
    else if (!open) modelState = 2;
  endfunction

  function automatic bit modelMove(logic [3:0] dir, int e0);
    bit changed = 0;
    logic [15:0] lineIn, lineOut;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) lineIn[4*j +: 4] = 4'(model[cellOf(dir, k, j)]);
      lineOut = mergeLine(lineIn);
      if (lineOut != lineIn) changed = 1;
      for (int j = 0; j < 4; j++) model[cellOf(dir, k, j)] = int'(lineOut[4*j +: 4]);
    end
    if (changed) modelSpawn(lfsrAt(e0 + 4));
    modelCheck();
    return changed;
  endfunction

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    int busyCycles = 0;
    int tiles = 0;
    rst = 1'b0;
    direction = '0;
    loadEn = 1'b0;
    loadGrid = '0;
    repeat (3) step();
    checkOutput("resetGrid", gridFlat, 64'd0);
    checkOutput("resetState", 64'(state), 64'd0);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(moveDone), 64'd0);
    rst = 1'b1;
    #1;
    while (busy && busyCycles < 10) begin
      busyCycles++;
      step();
    end
    checkOutput("initBusyCycles", 64'(busyCycles), 64'd2);
    for (int i = 0; i < 16; i++) model[i] = 0;
    modelState = 0;
    modelSpawn(lfsrAt(0));
    modelSpawn(lfsrAt(1));
    for (int i = 0; i < 16; i++)
      if (gridFlat[4*i +: 4] == 4'd1 || gridFlat[4*i +: 4] == 4'd2) tiles++;
    checkOutput("initTileCount", 64'(tiles), 64'd2);
    checkOutput("initGrid", gridFlat, packModel());
    checkOutput("initState", 64'(state), 64'd0);
  endtask

  task automatic loadBoard(input int cells[16]);
    for (int i = 0; i < 16; i++) loadGrid[4*i +: 4] = 4'(cells[i]);
    loadEn = 1'b1;
    step();
    loadEn = 1'b0;
    step();
    for (int i = 0; i < 16; i++) model[i] = cells[i];
    modelCheck();
    checkOutput("loadDone", 64'(moveDone), 64'd1);
    checkOutput("loadGrid", gridFlat, packModel());
    checkOutput("loadState", 64'(state), 64'(modelState));
  endtask

  task automatic applyStimulus(input logic [3:0] dir, input int holdCycles);
    bit accept;
    bit changed;
    int e0;
    int doneSeen = 0;
    int doneAt = -1;
    int lastC;
    logic [15:0] expLine;
    direction = '0;
    step();
    accept = (dir inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) && modelState == 0;
    direction = dir;
    step();
    e0 = edgeCount;
    if (holdCycles <= 1) direction = '0;
    if (accept) begin
      for (int j = 0; j < 4; j++) expLine[4*j +: 4] = 4'(model[cellOf(dir, 0, j)]);
      checkOutput("line0", 64'(lineToMerge), 64'(expLine));
      checkOutput("busyMove", 64'(busy), 64'd1);
      changed = modelMove(dir, e0);
    end
    lastC = (holdCycles + 2 > 12) ? holdCycles + 2 : 12;
    for (int c = 1; c <= lastC; c++) begin
      if (c >= holdCycles) direction = '0;
      step();
      if (moveDone) begin
        doneSeen++;
        if (doneAt < 0) doneAt = c;
      end
    end
    if (accept) begin
      checkOutput("doneCount", 64'(doneSeen), 64'd1);
      checkOutput("doneLatency", 64'(doneAt), 64'd6);
    end else begin
      checkOutput("noMove", 64'(doneSeen), 64'd0);
    end
    checkOutput("gridAfter", gridFlat, packModel());
    checkOutput("stateAfter", 64'(state), 64'(modelState));
    checkOutput("idleBusy", 64'(busy), 64'd0);
  endtask

  initial begin
    int b[16];
    int r;
    doReset();

    for (int i = 0; i < 16; i++) b[i] = 0;
    b[0] = 1; b[1] = 1; b[2] = 2;
    loadBoard(b);
    applyStimulus(4'b0001, 1);
    checkOutput("rightCells23", 64'(gridFlat[15:8]), 64'h22);

    for (int i = 0; i < 16; i++) b[i] = 0;
    b[1] = 2; b[3] = 2;
    loadBoard(b);
    applyStimulus(4'b1000, 1);
    checkOutput("leftCell0", 64'(gridFlat[3:0]), 64'd3);

    for (int i = 0; i < 16; i++) b[i] = 0;
    b[0] = 1;
    loadBoard(b);
    applyStimulus(4'b1000, 1);
    applyStimulus(4'b0100, 1);
    checkOutput("stuckGrid", gridFlat, 64'd1);

    for (int i = 0; i < 16; i++) b[i] = 0;
    b[2] = 10; b[3] = 10;
    loadBoard(b);
    applyStimulus(4'b0001, 1);
    checkOutput("winCell3", 64'(gridFlat[15:12]), 64'd11);
    checkOutput("winState", 64'(state), 64'd1);
    applyStimulus(4'b0010, 1);
    for (int i = 0; i < 16; i++) b[i] = (((i / 4) + (i % 4)) % 2 != 0) ? 2 : 1;
    loadBoard(b);
    checkOutput("wonSticky", 64'(state), 64'd1);

    doReset();
    loadBoard(b);
    checkOutput("lostState", 64'(state), 64'd2);
    applyStimulus(4'b0100, 1);

    doReset();
    for (int i = 0; i < 16; i++) b[i] = 0;
    b[0] = 1; b[1] = 1;
    loadBoard(b);
    applyStimulus(4'b0001, 20);
    applyStimulus(4'b0011, 1);

    // Random play; a mid-run reset clears any sticky won/lost state.
    for (int it = 0; it < 80; it++) begin
      if (it == 40) doReset();
      r = $urandom_range(0, 11);
      if (r == 0) begin
        for (int i = 0; i < 16; i++)
          b[i] = ($urandom_range(0, 63) == 0) ? 11 : int'($urandom_range(0, 3));
        loadBoard(b);
      end else if (r == 1) begin
        applyStimulus(4'($urandom_range(0, 15)), 1);
      end else begin
        applyStimulus(4'(1 << $urandom_range(0, 3)), ($urandom_range(0, 4) == 0) ? 3 : 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
